// File: rtl/synth_env_pkg.sv
// rtl/synth_env_pkg.sv - shared ADSR envelope encodings and scaling constants
package synth_env_pkg;

    localparam int ENV_W = 16;
    localparam int ST_W  = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    // Sustain byte sits in the top 8 bits of the envelope word.
    function automatic int sus_shift(input int w);
        return w - 8;
    endfunction

    // Attack aims 25% above full scale so the curve reaches the ceiling in finite steps.
    function automatic logic [63:0] overshoot_target(input int w);
        return (64'd1 << w) + (64'd1 << (w - 2));
    endfunction

    localparam int SUS_SHIFT = sus_shift(ENV_W);
    localparam logic [ENV_W+1:0] OVERSHOOT_T = (ENV_W+2)'(overshoot_target(ENV_W));

endpackage

// File: rtl/adsr_env_step.sv
// rtl/adsr_env_step.sv - one envelope step for one channel (pure combinational)
module adsr_env_step
    import synth_env_pkg::*;
#(
    parameter int W = 16
) (
    input  env_state_e   state_i,
    input  logic [W-1:0] env_i,
    input  logic         gate_i,
    input  logic [4:0]   attack_tau,
    input  logic [4:0]   decay_tau,
    input  logic [4:0]   release_tau,
    input  logic [W-1:0] sus_i,
    output env_state_e   state_o,
    output logic [W-1:0] env_o
);

    localparam logic [W+1:0] OVR_T   = (W+2)'(overshoot_target(W));
    localparam logic [W+1:0] ENV_MAX = {2'b00, {W{1'b1}}};
    localparam logic [W+1:0] ONE     = (W+2)'(1);

    logic [W+1:0] env_x;
    logic [W+1:0] sus_x;
    logic [W+1:0] a_inc;
    logic [W+1:0] d_dec;
    logic [W+1:0] r_dec;
    logic [W+1:0] a_sum;
    logic [W+1:0] d_res;
    logic [W+1:0] r_res;
    env_state_e   eff;

    // Gate-driven transition first, then the step of the resulting phase in the same update.
    always_comb begin
        env_x = {2'b00, env_i};
        sus_x = {2'b00, sus_i};

        a_inc = (OVR_T - env_x) >> attack_tau;
        if (a_inc == '0) a_inc = ONE;
        d_dec = (env_x - sus_x) >> decay_tau;
        if (d_dec == '0) d_dec = ONE;
        r_dec = env_x >> release_tau;
        if (r_dec == '0) r_dec = ONE;

        a_sum = env_x + a_inc;
        d_res = env_x - d_dec;
        r_res = env_x - r_dec;

        if (gate_i) begin
            eff = (state_i == ST_IDLE || state_i == ST_RELEASE) ? ST_ATTACK : state_i;
        end else begin
            eff = (state_i == ST_IDLE) ? ST_IDLE : ST_RELEASE;
        end

        state_o = ST_IDLE;
        env_o   = '0;
        case (eff)
            ST_IDLE: begin
                state_o = ST_IDLE;
                env_o   = '0;
            end
            ST_ATTACK: begin
                if (a_sum >= ENV_MAX) begin
                    state_o = ST_DECAY;
                    env_o   = {W{1'b1}};
                end else begin
                    state_o = ST_ATTACK;
                    env_o   = a_sum[W-1:0];
                end
            end
            ST_DECAY: begin
                if (env_x <= sus_x || d_res <= sus_x) begin
                    state_o = ST_SUSTAIN;
                    env_o   = sus_i;
                end else begin
                    state_o = ST_DECAY;
                    env_o   = d_res[W-1:0];
                end
            end
            ST_SUSTAIN: begin
                state_o = ST_SUSTAIN;
                env_o   = sus_i;
            end
            ST_RELEASE: begin
                if (env_x == '0 || r_res == '0) begin
                    state_o = ST_IDLE;
                    env_o   = '0;
                end else begin
                    state_o = ST_RELEASE;
                    env_o   = r_res[W-1:0];
                end
            end
            default: begin
                state_o = ST_IDLE;
                env_o   = '0;
            end
        endcase
    end

endmodule

// File: rtl/adsr_env_gen.sv
// rtl/adsr_env_gen.sv - time-multiplexed per-channel ADSR envelope generator
module adsr_env_gen
    import synth_env_pkg::*;
#(
    parameter int C_NUM_CHAN  = 16,
    parameter int C_ENV_WIDTH = 16
) (
    input  logic                              s_axi_aclk,
    input  logic                              s_axi_aresetn,
    input  logic                              sample_en,
    input  logic [C_NUM_CHAN-1:0]             gate,
    input  logic [4:0]                        attack_tau,
    input  logic [4:0]                        decay_tau,
    input  logic [4:0]                        release_tau,
    input  logic [7:0]                        sustain_lvl,
    output logic [C_NUM_CHAN*C_ENV_WIDTH-1:0] env_out,
    output logic                              env_valid,
    output logic                              busy,
    output logic                              overrun
);

    localparam int W     = C_ENV_WIDTH;
    localparam int CNT_W = (C_NUM_CHAN > 1) ? $clog2(C_NUM_CHAN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(C_NUM_CHAN - 1);

    logic [W-1:0]            env_q   [C_NUM_CHAN];
    logic [W-1:0]            env_d   [C_NUM_CHAN];
    env_state_e              state_q [C_NUM_CHAN];
    env_state_e              state_d [C_NUM_CHAN];
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    env_valid_q, env_valid_d;
    logic                    overrun_q, overrun_d;
    logic [C_NUM_CHAN-1:0]   gate_q, gate_d;
    logic [4:0]              atau_q, atau_d;
    logic [4:0]              dtau_q, dtau_d;
    logic [4:0]              rtau_q, rtau_d;
    logic [7:0]              sus_q, sus_d;

    logic [W-1:0]            sus_scaled;
    env_state_e              step_state;
    logic [W-1:0]            step_env;

    assign sus_scaled = W'(sus_q) << sus_shift(W);

    adsr_env_step #(.W(W)) u_step (
        .state_i     (state_q[cnt_q]),
        .env_i       (env_q[cnt_q]),
        .gate_i      (gate_q[cnt_q]),
        .attack_tau  (atau_q),
        .decay_tau   (dtau_q),
        .release_tau (rtau_q),
        .sus_i       (sus_scaled),
        .state_o     (step_state),
        .env_o       (step_env)
    );

    // Scan sequencing: accept a tick when idle, then write back one channel per clock.
    always_comb begin
        env_d       = env_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        env_valid_d = 1'b0;
        overrun_d   = 1'b0;
        gate_d      = gate_q;
        atau_d      = atau_q;
        dtau_d      = dtau_q;
        rtau_d      = rtau_q;
        sus_d       = sus_q;
        if (busy_q) begin
            env_d[cnt_q]   = step_env;
            state_d[cnt_q] = step_state;
            if (cnt_q == LAST) begin
                busy_d      = 1'b0;
                cnt_d       = '0;
                env_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            overrun_d = sample_en;
        end else if (sample_en) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            gate_d = gate;
            atau_d = attack_tau;
            dtau_d = decay_tau;
            rtau_d = release_tau;
            sus_d  = sustain_lvl;
        end
    end

    // State registers; reset may land mid-scan and clears everything at once.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int k = 0; k < C_NUM_CHAN; k++) begin
                env_q[k]   <= '0;
                state_q[k] <= ST_IDLE;
            end
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            env_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            gate_q      <= '0;
            atau_q      <= '0;
            dtau_q      <= '0;
            rtau_q      <= '0;
            sus_q       <= '0;
        end else begin
            env_q       <= env_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            env_valid_q <= env_valid_d;
            overrun_q   <= overrun_d;
            gate_q      <= gate_d;
            atau_q      <= atau_d;
            dtau_q      <= dtau_d;
            rtau_q      <= rtau_d;
            sus_q       <= sus_d;
        end
    end

    // Pack the per-channel envelope registers onto the output bus.
    always_comb begin
        env_out = '0;
        for (int k = 0; k < C_NUM_CHAN; k++) begin
            env_out[k*W +: W] = env_q[k];
        end
    end

    assign env_valid = env_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adsr_env_gen.sv
// tb/tb_adsr_env_gen.sv - scoreboard bench for adsr_env_gen with four channels
module tb_adsr_env_gen;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sample_en = 1'b0;
    logic [N-1:0]   gate = '0;
    logic [4:0]     at = '0;
    logic [4:0]     dt = '0;
    logic [4:0]     rt = '0;
    logic [7:0]     sus = '0;
    logic [N*W-1:0] env_out;
    logic           env_valid;
    logic           busy;
    logic           overrun;

    adsr_env_gen #(.C_NUM_CHAN(N), .C_ENV_WIDTH(W)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .sample_en     (sample_en),
        .gate          (gate),
        .attack_tau    (at),
        .decay_tau     (dt),
        .release_tau   (rt),
        .sustain_lvl   (sus),
        .env_out       (env_out),
        .env_valid     (env_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] env;
        int             cyc;
        string          name;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ovr_cnt = 0;
    int   valid_cnt = 0;
    int   pushed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] ev(input logic [15:0] e3, input logic [15:0] e2,
                                          input logic [15:0] e1, input logic [15:0] e0);
        return {e3, e2, e1, e0};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (overrun) ovr_cnt++;
        if (env_valid) begin
            valid_cnt++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: env_valid high at cycle %0d, required none", cyc);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_env"}, 64'(env_out), 64'(e.env));
                chk({e.name, "_lat"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic push_exp(input string nm, input logic [N*W-1:0] exp_env);
        exp_t e;
        e.env  = exp_env;
        e.cyc  = cyc + 1 + N;
        e.name = nm;
        sb_q.push_back(e);
        pushed++;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 4 * N && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no env_valid, required one", nm);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input string nm, input logic [N*W-1:0] exp_env);
        push_exp(nm, exp_env);
        sample_en = 1'b1;
        @(posedge clk);
        #1 sample_en = 1'b0;
        wait_drain(nm);
    endtask

    task automatic do_reset;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ovr0;
        int v0;

        #12;
        chk("rst_env", 64'(env_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(env_valid), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of a scan
        gate = 4'hF; sus = 8'h80; at = 0; dt = 0; rt = 0;
        sample_en = 1'b1;
        @(posedge clk);
        #1 sample_en = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy_pre", 64'(busy), 64'd1);
        chk("mid_env0_pre", 64'(env_out[15:0]), 64'hFFFF);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_env", 64'(env_out), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_valid", 64'(env_valid), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // instant ADSR on channel 0
        gate = 4'b0001; at = 0; dt = 0; rt = 0; sus = 8'h80;
        tick("adsr1", ev(16'h0, 16'h0, 16'h0, 16'hFFFF));
        tick("adsr2", ev(16'h0, 16'h0, 16'h0, 16'h8000));
        gate = 4'b0000;
        tick("adsr3", ev(16'h0, 16'h0, 16'h0, 16'h0000));

        // shaped attack on channel 1
        do_reset();
        gate = 4'b0010; at = 2;
        tick("shape1", ev(16'h0, 16'h0, 16'h5000, 16'h0));
        tick("shape2", ev(16'h0, 16'h0, 16'h8C00, 16'h0));

        // minimum-step climb then release on channel 2
        do_reset();
        gate = 4'b0100; at = 16;
        tick("min_a1", ev(16'h0, 16'h0001, 16'h0, 16'h0));
        tick("min_a2", ev(16'h0, 16'h0002, 16'h0, 16'h0));
        tick("min_a3", ev(16'h0, 16'h0003, 16'h0, 16'h0));
        gate = 4'b0000; rt = 20;
        tick("min_r1", ev(16'h0, 16'h0002, 16'h0, 16'h0));
        tick("min_r2", ev(16'h0, 16'h0001, 16'h0, 16'h0));
        tick("min_r3", ev(16'h0, 16'h0000, 16'h0, 16'h0));
        tick("min_idle", ev(16'h0, 16'h0000, 16'h0, 16'h0));

        // retrigger during release on channel 3
        do_reset();
        gate = 4'b1000; at = 0; dt = 0; rt = 0; sus = 8'h80;
        tick("re_att", ev(16'hFFFF, 16'h0, 16'h0, 16'h0));
        tick("re_sus", ev(16'h8000, 16'h0, 16'h0, 16'h0));
        gate = 4'b0000; rt = 1;
        tick("re_rel", ev(16'h4000, 16'h0, 16'h0, 16'h0));
        gate = 4'b1000; at = 0;
        tick("re_trig", ev(16'hFFFF, 16'h0, 16'h0, 16'h0));
        dt = 1;
        tick("re_decay", ev(16'hC000, 16'h0, 16'h0, 16'h0));

        // overrun: second request during the scan is dropped
        do_reset();
        gate = 4'b0001; at = 0; dt = 0; rt = 0; sus = 8'h80;
        ovr0 = ovr_cnt;
        v0 = valid_cnt;
        push_exp("ovr", ev(16'h0, 16'h0, 16'h0, 16'hFFFF));
        sample_en = 1'b1;
        @(posedge clk);
        #1 sample_en = 1'b0;
        @(posedge clk);
        #1 sample_en = 1'b1;
        @(posedge clk);
        #1 sample_en = 1'b0;
        chk("ovr_pulse", 64'(overrun), 64'd1);
        wait_drain("ovr");
        repeat (3 * N) @(posedge clk);
        #1;
        chk("ovr_count", 64'(ovr_cnt - ovr0), 64'd1);
        chk("ovr_valids", 64'(valid_cnt - v0), 64'd1);
        chk("valid_total", 64'(valid_cnt), 64'(pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
